// File: rtl/rate_sched_pkg.sv
// Shared types and defaults for the rate_sched multi-channel tick scheduler.
// Optional one-shot mode is enabled with the RATE_SCHED_ONESHOT_EN macro.
package rate_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } ch_mode_t;

  localparam int DEF_PRESCALE = 100_000;
  localparam int DEF_CNT_W    = 16;

  // A single channel still needs a one-bit address bus.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_sched_channel.sv
// One scheduler channel: IDLE/RUN FSM, down-counter and period register.
// With RATE_SCHED_ONESHOT_EN defined, a per-channel mode bit is latched at arm.
module rate_sched_channel
  import rate_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             arm,
  input  logic [CNT_W-1:0] period_in,
  input  logic             oneshot,
  input  logic             base_tick,
  output logic             tick,
  output logic             active
);

  ch_state_t        state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period;

`ifdef RATE_SCHED_ONESHOT_EN
  ch_mode_t mode;
`else
  logic unused_oneshot;
  assign unused_oneshot = oneshot;
`endif

  // A config write takes priority over a coincident base tick, so the
  // restarted count never loses or gains a tick on the arming cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      period  <= '0;
      tick    <= 1'b0;
      active  <= 1'b0;
`ifdef RATE_SCHED_ONESHOT_EN
      mode    <= PERIODIC;
`endif
    end else begin
      tick <= 1'b0;
      if (wr) begin
        if (arm && (period_in != '0)) begin
          period  <= period_in;
          counter <= period_in;
          state   <= RUN;
          active  <= 1'b1;
`ifdef RATE_SCHED_ONESHOT_EN
          mode    <= ch_mode_t'(oneshot);
`endif
        end else begin
          state   <= IDLE;
          counter <= '0;
          active  <= 1'b0;
        end
      end else if ((state == RUN) && base_tick) begin
        if (counter == CNT_W'(1)) begin
          tick <= 1'b1;
`ifdef RATE_SCHED_ONESHOT_EN
          if (mode == ONESHOT) begin
            state   <= IDLE;
            counter <= '0;
            active  <= 1'b0;
          end else begin
            counter <= period;
          end
`else
          counter <= period;
`endif
        end else begin
          counter <= counter - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rate_sched.sv
// Multi-channel tick scheduler: one shared base-tick prescaler feeding N_CH channels.
// Optional one-shot channel mode is compiled in with RATE_SCHED_ONESHOT_EN.
module rate_sched
  import rate_sched_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AW       = addr_width(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic             cfg_arm,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  output logic             base_tick,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  active
);

  localparam int            PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  // base_tick is registered, so it rises one cycle after the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= (presc == PMAX);
      presc     <= (presc == PMAX) ? '0 : presc + PW'(1);
    end
  end

  // Out-of-range addresses match no channel and are silently dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [AW-1:0] IDX = AW'(g);

    rate_sched_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr       (cfg_we && (cfg_addr == IDX)),
      .arm      (cfg_arm),
      .period_in(cfg_period),
      .oneshot  (cfg_oneshot),
      .base_tick(base_tick),
      .tick     (tick[g]),
      .active   (active[g])
    );
  end

endmodule

// File: tb/tb_rate_sched.sv
// Directed testbench for rate_sched with PRESCALE=4, N_CH=3 (address 3 is out of range).
// Expected one-shot behaviour follows RATE_SCHED_ONESHOT_EN when defined.
module tb_rate_sched;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic       cfg_arm;
  logic [7:0] cfg_period;
  logic       cfg_oneshot;
  logic       base_tick;
  logic [2:0] tick;
  logic [2:0] active;

  int total;
  int bad;
  int e;

  rate_sched #(
    .N_CH    (3),
    .PRESCALE(4),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_arm    (cfg_arm),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .base_tick  (base_tick),
    .tick       (tick),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // e counts rising edges since the last reset release; checks sit 1 time unit after each edge.
  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic arm, input logic [7:0] p,
                           input logic os);
    cfg_we      = 1'b1;
    cfg_addr    = a;
    cfg_arm     = arm;
    cfg_period  = p;
    cfg_oneshot = os;
    step();
    cfg_we      = 1'b0;
    cfg_arm     = 1'b0;
    cfg_period  = '0;
    cfg_oneshot = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    e = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_arm = 1'b0; cfg_period = '0; cfg_oneshot = 1'b0;
    e = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({base_tick, tick, active} !== 7'b0) begin
        $display("[TB] FAIL reset_hold got=%b want=0000000", {base_tick, tick, active});
        bad++;
      end
    end
    release_reset();
  endtask

  task automatic test_prescaler(input string name);
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if ({base_tick, tick, active} !== {(e % 4 == 0), 6'b0}) begin
        $display("[TB] FAIL %s e=%0d got=%b want=%b", name, e, {base_tick, tick, active},
                 {(e % 4 == 0), 6'b0});
        bad++;
      end
    end
  endtask

  task automatic test_periodic();
    step();
    cfg_write(2'd0, 1'b1, 8'd3, 1'b0);
    total++;
    if (active !== 3'b001) begin
      $display("[TB] FAIL arm_active got=%b want=001", active);
      bad++;
    end
    while (e < 40) begin
      step();
      total++;
      if ({base_tick, tick} !== {(e % 4 == 0), 2'b00, (e == 25 || e == 37)}) begin
        $display("[TB] FAIL periodic e=%0d got=%b want=%b", e, {base_tick, tick},
                 {(e % 4 == 0), 2'b00, (e == 25 || e == 37)});
        bad++;
      end
    end
  endtask

  task automatic test_arm_on_base_tick();
    cfg_write(2'd1, 1'b1, 8'd2, 1'b0);
    total++;
    if (active !== 3'b011) begin
      $display("[TB] FAIL arm1_active got=%b want=011", active);
      bad++;
    end
    while (e < 66) begin
      step();
      total++;
      if (tick !== {1'b0, (e == 49 || e == 57 || e == 65), (e == 49 || e == 61)}) begin
        $display("[TB] FAIL same_cycle e=%0d got=%b want=%b", e, tick,
                 {1'b0, (e == 49 || e == 57 || e == 65), (e == 49 || e == 61)});
        bad++;
      end
    end
  endtask

  task automatic test_disarm();
    while (e < 71) step();
    cfg_write(2'd0, 1'b0, 8'd0, 1'b0);
    total++;
    if (active !== 3'b010) begin
      $display("[TB] FAIL disarm_active got=%b want=010", active);
      bad++;
    end
    while (e < 82) begin
      step();
      total++;
      if (tick !== {1'b0, (e == 73 || e == 81), 1'b0}) begin
        $display("[TB] FAIL disarm e=%0d got=%b want=%b", e, tick,
                 {1'b0, (e == 73 || e == 81), 1'b0});
        bad++;
      end
    end
  endtask

  task automatic test_zero_period_bad_addr();
    cfg_write(2'd0, 1'b1, 8'd2, 1'b0);
    total++;
    if (active !== 3'b011) begin
      $display("[TB] FAIL rearm_active got=%b want=011", active);
      bad++;
    end
    cfg_write(2'd0, 1'b1, 8'd0, 1'b0);
    total++;
    if (active !== 3'b010) begin
      $display("[TB] FAIL zero_period got=%b want=010", active);
      bad++;
    end
    cfg_write(2'd3, 1'b0, 8'd0, 1'b0);
    cfg_write(2'd3, 1'b1, 8'd1, 1'b0);
    total++;
    if (active !== 3'b010) begin
      $display("[TB] FAIL bad_addr got=%b want=010", active);
      bad++;
    end
    while (e < 98) begin
      step();
      total++;
      if ({tick, active} !== {1'b0, (e == 89 || e == 97), 1'b0, 3'b010}) begin
        $display("[TB] FAIL bad_addr_run e=%0d got=%b want=%b", e, {tick, active},
                 {1'b0, (e == 89 || e == 97), 1'b0, 3'b010});
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_count();
    cfg_write(2'd0, 1'b1, 8'd1, 1'b0);
    total++;
    if (active !== 3'b011) begin
      $display("[TB] FAIL pre_reset got=%b want=011", active);
      bad++;
    end
    reset = 1'b1;
    #2;
    total++;
    if ({base_tick, tick, active} !== 7'b0) begin
      $display("[TB] FAIL async_reset got=%b want=0000000", {base_tick, tick, active});
      bad++;
    end
    step();
    step();
    release_reset();
    test_prescaler("post_reset");
  endtask

  task automatic test_oneshot();
    logic [2:0] exp_tick;
    logic [2:0] exp_active;
    step();
    cfg_write(2'd2, 1'b1, 8'd1, 1'b1);
    total++;
    if (active !== 3'b100) begin
      $display("[TB] FAIL arm2_active got=%b want=100", active);
      bad++;
    end
    while (e < 30) begin
      step();
`ifdef RATE_SCHED_ONESHOT_EN
      exp_tick   = {(e == 17), 2'b00};
      exp_active = (e < 17) ? 3'b100 : 3'b000;
`else
      exp_tick   = {(e == 17 || e == 21 || e == 25 || e == 29), 2'b00};
      exp_active = 3'b100;
`endif
      total++;
      if ({tick, active} !== {exp_tick, exp_active}) begin
        $display("[TB] FAIL oneshot e=%0d got=%b want=%b", e, {tick, active},
                 {exp_tick, exp_active});
        bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_prescaler("prescaler");
    test_periodic();
    test_arm_on_base_tick();
    test_disarm();
    test_zero_period_bad_addr();
    test_reset_mid_count();
    test_oneshot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rate_sched.md
Name: rate_sched

Overview:
- Multi-channel tick scheduler that shares one base-tick prescaler among N_CH independent software-configured channels.
- Each channel counts base ticks down from a programmed period and emits a one-clock TICK pulse on expiry.
- Sits between the system clock and consumers of slow timing pulses (cursor blink, key auto-repeat, display refresh).
- Replaces per-consumer free-running dividers with one configurable controller.

Parameters:
- N_CH, 4, number of channels (>=1).
- PRESCALE, 100_000, base-tick period in CLK cycles (>=2); 1 ms at 100 MHz.
- CNT_W, 16, channel period/counter width.
- AW, $clog2(N_CH) (min 1), config address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- CFG_WE  in  1  config write strobe, one cycle per write.
- CFG_ADDR  in  AW  target channel.
- CFG_ARM  in  1  1 = arm/restart channel, 0 = disarm.
- CFG_PERIOD  in  CNT_W  period in base ticks.
- CFG_ONESHOT  in  1  mode select; used only when the optional feature is compiled in.
- BASE_TICK  out  1  one-cycle pulse every PRESCALE clocks.
- TICK  out  N_CH  per-channel one-cycle expiry pulse, registered.
- ACTIVE  out  N_CH  per-channel armed status, registered.

Behaviour:
- Reset (async, RESET high): prescaler=0; all channels IDLE with counter=0, period=0.
  - BASE_TICK=0, TICK=0, ACTIVE=0 immediately, held while RESET is high.
- Prescaler: counts 0..PRESCALE-1, wraps to 0. BASE_TICK=1 in the cycle after prescaler==PRESCALE-1, i.e. registered, period exactly PRESCALE clocks.
  - First BASE_TICK occurs PRESCALE clocks after reset release.
- Channel FSM states: IDLE, RUN.
- Config write (CFG_WE=1, CFG_ADDR<N_CH):
  - If ARM=1 and PERIOD!=0: period<=PERIOD, counter<=PERIOD, state<=RUN, ACTIVE=1 next cycle.
  - If ARM=0 or PERIOD==0: state<=IDLE, counter<=0, ACTIVE=0 next cycle. A pending TICK is not generated.
  - Writes to a channel already in RUN restart it with the new period.
- CFG_ADDR>=N_CH: write ignored, no state change anywhere.
- RUN, on BASE_TICK=1:
  - counter>1: counter decrements.
  - counter==1: TICK[ch]=1 next cycle, and counter<=period (periodic reload).
- Latency: the first TICK follows the P-th BASE_TICK strictly after the arming write cycle. Each subsequent TICK comes every P base ticks. TICK lags the causing BASE_TICK by 1 cycle.
- Simultaneous write and BASE_TICK on the same channel: the write wins and the base tick is not counted. Other channels still see the base tick.
- Counter arithmetic is unsigned CNT_W; no underflow possible (never decrements from 0). Max period 2^CNT_W-1.
- Channels are fully independent; any number of TICK bits may assert in the same cycle.
- RESET asserted mid-count: all state is lost; channels must be re-armed.

Optional Feature:
- Macro: RATE_SCHED_ONESHOT_EN.
- Defined: CFG_ONESHOT is latched per channel at arm.
  - On expiry, a one-shot channel pulses TICK and goes IDLE with counter=0. ACTIVE falls in the same cycle TICK rises.
  - Periodic channels are unchanged.
- Undefined: CFG_ONESHOT is ignored, no mode register is built, and all channels are periodic.

Decomposition:
- Package rate_sched_pkg:
  - Channel state encoding (IDLE=1'b0, RUN=1'b1).
  - Default PRESCALE/CNT_W constants.
  - Mode encoding (PERIODIC=0, ONESHOT=1).
- Sub-module rate_sched_channel: one channel FSM, counter and period register. Generated N_CH times.
- The prescaler stays in rate_sched.

Test Plan:
- PRESCALE=4, reset release -> BASE_TICK pulses at clocks 4, 8, 12, ...; TICK=0, ACTIVE=0 throughout.
- Arm ch0 with PERIOD=3 -> ACTIVE[0]=1 next cycle; TICK[0] 1 cycle after the 3rd subsequent BASE_TICK, then every 12 clocks.
- Arm ch1 with PERIOD=2 in the same cycle as BASE_TICK -> that base tick is not counted; the first TICK[1] follows the next 2 base ticks. Ch0 timing is unaffected.
- Disarm ch0 (ARM=0) when counter==1, one cycle before BASE_TICK -> no TICK[0]; ACTIVE[0]=0; PERIOD=0 with ARM=1 gives the same result. Write to CFG_ADDR=N_CH -> no change.
- Assert RESET mid-count with ch0/ch1 running -> all outputs 0 asynchronously; after release there is no TICK until re-armed.
- With RATE_SCHED_ONESHOT_EN: arm ch2 PERIOD=1, ONESHOT=1 -> exactly one TICK[2], ACTIVE[2] falls with it. Without the macro -> TICK[2] every base tick.
